// File: rtl/ppc_sum_ctl.sv
// Receive-side controller for the pipelined parallel-prefix adder: valid tracking, sum
// formation, credit-throttled result FIFO. Define PPC_SUM_OVF_EN to store signed overflow.
module ppc_sum_ctl #(
  parameter int unsigned LAT   = 6,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [255:0]    pp_y,
  input  logic [31:0]     pp_c,
  input  logic [31:0]     pp_d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_sum,
  output logic            out_cout,
  output logic            out_ovf,
  output logic [CW-1:0]   credits
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PPC_SUM_OVF_EN
  localparam int unsigned EW = 34;
`else
  localparam int unsigned EW = 33;
`endif

  logic [LAT-1:0] vld_q, vld_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d, inflight_q, inflight_d;
  logic           iss_ready_q, iss_ready_d;
  logic [EW-1:0]  mem_q [DEPTH];
  logic [EW-1:0]  entry, head;
  logic [31:0]    sum;
  logic           cout, fire, cap, pop, unused_y;
  logic [CW:0]    total_d;

  assign fire = iss_valid & iss_ready_q;
  assign cap  = vld_q[LAT-1];
  assign pop  = out_valid & out_ready;

  // Lane i bit0 is the group generate G[i:0], i.e. the carry into bit i+1.
  always_comb begin
    sum[0]   = pp_c[0] ^ pp_d[0];
    unused_y = 1'b0;
    for (int i = 1; i < 32; i++) begin
      sum[i] = pp_c[i] ^ pp_d[i] ^ pp_y[8*(i-1)];
    end
    for (int i = 0; i < 32; i++) begin
      unused_y = unused_y ^ (^pp_y[8*i+1 +: 7]);
    end
    cout = pp_y[8*31];
  end

`ifdef PPC_SUM_OVF_EN
  assign entry = {(pp_c[31] == pp_d[31]) & (sum[31] != pp_c[31]), cout, sum};
`else
  assign entry = {cout, sum};
`endif

  always_comb begin
    vld_d      = vld_q << 1;
    vld_d[0]   = fire;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (cap) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    count_d    = count_q + CW'(cap) - CW'(pop);
    inflight_d = inflight_q + CW'(fire) - CW'(cap);
    // Next-state occupancy; a pop this cycle frees its slot for next cycle's issue.
    total_d     = {1'b0, inflight_d} + {1'b0, count_d};
    iss_ready_d = total_d < (CW+1)'(DEPTH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
      iss_ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      iss_ready_q <= iss_ready_d;
      if (cap) mem_q[wr_ptr_q] <= entry;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign iss_ready = iss_ready_q;
  assign out_valid = (count_q != '0);
  assign out_sum   = head[31:0];
  assign out_cout  = head[32];
`ifdef PPC_SUM_OVF_EN
  assign out_ovf   = head[33];
`else
  assign out_ovf   = 1'b0;
`endif
  assign credits   = CW'(DEPTH) - (inflight_q + count_q);

endmodule

// File: tb/tb_ppc_sum_ctl.sv
// Directed bench for ppc_sum_ctl with a behavioural 6-stage prefix pipeline model.
module tb_ppc_sum_ctl;

  localparam int unsigned LAT = 6;
`ifdef PPC_SUM_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         iss_valid, iss_ready, out_valid, out_ready, out_cout, out_ovf;
  logic [255:0] pp_y;
  logic [31:0]  pp_c, pp_d, out_sum, a_in, b_in;
  logic [3:0]   credits;

  logic [31:0] st_a [LAT];
  logic [31:0] st_b [LAT];
  logic [31:0] st_j [LAT];

  logic [33:0] exp_q [$];
  int n_total = 0, n_bad = 0, n_fire = 0, n_pop = 0, n_drop = 0, inv_bad = 0;
  bit watch_drop = 1'b0;

  ppc_sum_ctl dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .pp_y(pp_y), .pp_c(pp_c), .pp_d(pp_d), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .credits(credits)
  );

  always #5 clk = ~clk;

  // Ripple reference for the prefix network; bits 7:2 of each lane carry junk.
  function automatic logic [255:0] mk_y(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] j);
    logic [255:0] y;
    logic c, p;
    c = 1'b0;
    p = 1'b1;
    for (int i = 0; i < 32; i++) begin
      c = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      p = p & (a[i] ^ b[i]);
      y[8*i]      = c;
      y[8*i+1]    = p;
      y[8*i+2 +: 6] = 6'(j >> i);
    end
    return y;
  endfunction

  always @(posedge clk) begin
    st_a[0] <= a_in;
    st_b[0] <= b_in;
    st_j[0] <= $urandom;
    for (int i = 1; i < LAT; i++) begin
      st_a[i] <= st_a[i-1];
      st_b[i] <= st_b[i-1];
      st_j[i] <= st_j[i-1];
    end
  end

  always @* begin
    pp_c = st_a[LAT-1];
    pp_d = st_b[LAT-1];
    pp_y = mk_y(st_a[LAT-1], st_b[LAT-1], st_j[LAT-1]);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic ov;
    s  = {1'b0, a} + {1'b0, b};
    ov = OVF_ON & (a[31] == b[31]) & (s[31] != a[31]);
    return {ov, s};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (iss_valid && iss_ready) begin
        exp_q.push_back(model(a_in, b_in));
        n_fire++;
      end
      if (watch_drop && iss_valid && !iss_ready) n_drop++;
      if ({1'b0, dut.inflight_q} + {1'b0, dut.count_q} > 5'd8) inv_bad++;
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) check_eq("unexpected_pop", 64'd1, 64'd0);
        else check_eq("result", {30'd0, out_ovf, out_cout, out_sum}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] es, input logic ec, input logic eo);
    tick();
    iss_valid = 1'b1;
    a_in = a;
    b_in = b;
    tick();
    iss_valid = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    repeat (LAT - 1) tick();
    check_eq({tag, "_early"}, 64'(out_valid), 64'd0);
    tick();
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_sum"}, 64'(out_sum), 64'(es));
    check_eq({tag, "_cout"}, 64'(out_cout), 64'(ec));
    check_eq({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
    repeat (3) tick();
    check_eq({tag, "_held"}, {31'd0, out_valid, out_sum}, {31'd1, es});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_popped"}, 64'(out_valid), 64'd0);
  endtask

  int base;
  logic [31:0] ta [6] = '{32'h0, 32'h80000000, 32'h12345678, 32'hFFFFFFFF, 32'h1, 32'hDEADBEEF};
  logic [31:0] tb [6] = '{32'h0, 32'h80000000, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'h7FFFFFFF,
                          32'h21524111};

  initial begin
    rst = 1'b0;
    iss_valid = 1'b0;
    out_ready = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (3) tick();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_credits", 64'(credits), 64'd8);
    check_eq("rst_iss_ready", 64'(iss_ready), 64'd0);
    check_eq("rst_out_data", {31'd0, out_ovf, out_cout, out_sum}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("release_ready_low", 64'(iss_ready), 64'd0);
    tick();
    check_eq("release_ready_high", 64'(iss_ready), 64'd1);

    run_one("wrap", 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    run_one("mix", 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0, 1'b0);
    run_one("carry_all", 32'hDEADBEEF, 32'h21524111, 32'h00000000, 1'b1, 1'b0);
    run_one("ovf_pos", 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, OVF_ON);
    run_one("ovf_neg", 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, OVF_ON);

    // Streaming: directed table first, then random pairs.
    base = n_pop;
    out_ready = 1'b1;
    watch_drop = 1'b1;
    iss_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a_in = (i < 6) ? ta[i] : $urandom;
      b_in = (i < 6) ? tb[i] : $urandom;
      tick();
    end
    iss_valid = 1'b0;
    watch_drop = 1'b0;
    repeat (LAT + 4) tick();
    check_eq("stream_pops", 64'(n_pop - base), 64'd100);
    check_eq("stream_ready_drops", 64'(n_drop), 64'd0);
    check_eq("stream_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: exactly DEPTH issues accepted.
    base = n_fire;
    out_ready = 1'b0;
    iss_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_in = $urandom;
      b_in = $urandom;
      tick();
    end
    iss_valid = 1'b0;
    check_eq("bp_accepted", 64'(n_fire - base), 64'd8);
    check_eq("bp_ready_low", 64'(iss_ready), 64'd0);
    check_eq("bp_credits", 64'(credits), 64'd0);
    check_eq("bp_out_valid", 64'(out_valid), 64'd1);
    base = n_pop;
    out_ready = 1'b1;
    repeat (12) tick();
    check_eq("bp_drain_pops", 64'(n_pop - base), 64'd8);
    check_eq("bp_ready_back", 64'(iss_ready), 64'd1);
    check_eq("bp_credits_back", 64'(credits), 64'd8);

    // Reset with 3 in flight and 2 buffered.
    out_ready = 1'b0;
    iss_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_in = $urandom;
      b_in = $urandom;
      tick();
    end
    iss_valid = 1'b0;
    repeat (3) tick();
    check_eq("mid_credits", 64'(credits), 64'd3);
    check_eq("mid_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_credits", 64'(credits), 64'd8);
    check_eq("mid_rst_ready", 64'(iss_ready), 64'd0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    out_ready = 1'b1;
    base = n_pop;
    repeat (15) tick();
    check_eq("post_rst_no_pop", 64'(n_pop - base), 64'd0);
    check_eq("post_rst_valid", 64'(out_valid), 64'd0);
    check_eq("post_rst_credits", 64'(credits), 64'd8);

    check_eq("occupancy_invariant", 64'(inv_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
